// File: rtl/gate_sequence_accumulator.sv
// Folds a stream of 2x2 complex gates into a running unitary U <- G x U using an
// external complex matrix multiplier, then holds the composite until acknowledged.
module gate_sequence_accumulator #(
  parameter int WIDTH       = 19,
  parameter int ONE         = 131072,
  parameter int MUL_TIMEOUT = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [0:1][0:1][0:1][WIDTH-1:0]    gate_mtx,
  input  logic                               gate_valid,
  input  logic                               gate_last,
  output logic                               gate_ready,
  output logic [0:1][0:1][0:1][WIDTH-1:0]    mul_a,
  output logic [0:1][0:1][0:1][WIDTH-1:0]    mul_b,
  output logic                               mul_ready,
  input  logic [0:1][0:1][0:1][WIDTH-1:0]    mul_r,
  input  logic                               mul_completed,
  output logic [0:1][0:1][0:1][WIDTH-1:0]    result_mtx,
  output logic                               result_valid,
  input  logic                               result_ack,
  output logic [7:0]                         gate_count,
  output logic                               error
);

  typedef logic [0:1][0:1][0:1][WIDTH-1:0] mtx_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  localparam int TW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MUL_TIMEOUT - 1);

  function automatic mtx_t identity_mtx();
    mtx_t m;
    m = '0;
    m[0][0][0] = WIDTH'(ONE);
    m[1][1][0] = WIDTH'(ONE);
    return m;
  endfunction

  localparam mtx_t IDENTITY = identity_mtx();

  state_t          state_q, state_d;
  mtx_t            acc_q, acc_d;
  mtx_t            gbuf_q, gbuf_d;
  logic            last_q, last_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      count_q, count_d;
  logic            error_q, error_d;
  logic            gate_ready_q, gate_ready_d;
  logic            mul_ready_q, mul_ready_d;
  logic            result_valid_q, result_valid_d;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    gbuf_d         = gbuf_q;
    last_d         = last_q;
    tmo_d          = tmo_q;
    count_d        = count_q;
    error_d        = error_q;
    gate_ready_d   = 1'b0;
    mul_ready_d    = 1'b0;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (gate_valid && gate_ready_q) begin
          gbuf_d  = gate_mtx;
          last_d  = gate_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A product arriving in the final allowed cycle still wins over the timeout.
        if (mul_completed) begin
          acc_d   = mul_r;
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          state_d = last_q ? DONE : IDLE;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        if (result_ack && result_valid_q) begin
          acc_d   = IDENTITY;
          count_d = 8'd0;
          state_d = IDLE;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered decodes of the state being entered.
    gate_ready_d   = (state_d == IDLE);
    mul_ready_d    = (state_d == ISSUE);
    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      acc_q          <= IDENTITY;
      gbuf_q         <= '0;
      last_q         <= 1'b0;
      tmo_q          <= '0;
      count_q        <= 8'd0;
      error_q        <= 1'b0;
      gate_ready_q   <= 1'b0;
      mul_ready_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      gbuf_q         <= gbuf_d;
      last_q         <= last_d;
      tmo_q          <= tmo_d;
      count_q        <= count_d;
      error_q        <= error_d;
      gate_ready_q   <= gate_ready_d;
      mul_ready_q    <= mul_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign gate_ready   = gate_ready_q;
  assign mul_ready    = mul_ready_q;
  assign result_valid = result_valid_q;
  assign mul_a        = gbuf_q;
  assign mul_b        = acc_q;
  assign result_mtx   = acc_q;
  assign gate_count   = count_q;
  assign error        = error_q;

endmodule

// File: doc/gate_sequence_accumulator.md
Name: gate_sequence_accumulator

Overview:
- Upstream/downstream controller for complex_matrix_multiplier.
- Accepts a stream of 2x2 complex gate matrices (19-bit signed, Q1.17) over a valid/ready handshake.
- Folds each gate into a running unitary U <- G x U by driving the multiplier and capturing its result.
- Presents the final composite matrix to the compiler back end when the last gate of a sequence has been folded.

Parameters:
- WIDTH, 19: bit width of each real/imaginary component.
- ONE, 131072: fixed-point encoding of +1.0 (Q1.17), used for identity load.
- MUL_TIMEOUT, 8: cycles to wait for mul_completed before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- gate_mtx  in  WIDTH x[0:1][0:1][0:1]  incoming gate, indexed [row][col][0=re,1=im].
- gate_valid  in  1  gate_mtx/gate_last valid.
- gate_last  in  1  this gate ends the sequence.
- gate_ready  out  1  block can accept a gate.
- mul_a  out  WIDTH x[0:1][0:1][0:1]  multiplier left operand (gate).
- mul_b  out  WIDTH x[0:1][0:1][0:1]  multiplier right operand (accumulator).
- mul_ready  out  1  one-cycle start pulse to multiplier.
- mul_r  in  WIDTH x[0:1][0:1][0:1]  multiplier product.
- mul_completed  in  1  product valid strobe.
- result_mtx  out  WIDTH x[0:1][0:1][0:1]  composite unitary.
- result_valid  out  1  result_mtx valid; held until acked.
- result_ack  in  1  consumer accepts result.
- gate_count  out  8  gates folded in current sequence; saturates at 255.
- error  out  1  sticky multiplier-timeout flag.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- Reset (async, reset_n=0):
  - state=IDLE.
  - Accumulator = identity: [0][0][0]=[1][1][0]=ONE, all other components 0.
  - gate buffer = 0.
  - gate_ready=0, mul_ready=0, result_valid=0, gate_count=0, error=0.
  - Reset mid-sequence discards all partial state.
- gate_ready is high only in IDLE (registered decode).
- IDLE:
  - On gate_valid & gate_ready: latch gate_mtx into gate buffer, latch gate_last, go to ISSUE.
  - gate_valid without ready is ignored; the source holds its data.
- ISSUE:
  - mul_ready=1 for exactly this one cycle.
  - mul_a = gate buffer, mul_b = accumulator; both are registers, stable from ISSUE through WAIT.
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - Nominal mul_completed arrives 2 cycles after the ISSUE cycle.
  - On mul_completed: accumulator <- mul_r, gate_count <- gate_count+1 (saturating).
  - Then go to DONE if the latched last flag is set, else IDLE.
  - If the counter reaches MUL_TIMEOUT without mul_completed: error=1, go to ERR.
  - mul_completed outside WAIT is ignored.
- DONE:
  - result_valid=1; result_mtx = accumulator (registered, held stable).
  - On result_ack: result_valid=0, accumulator <- identity, gate_count=0, go to IDLE.
  - result_ack while result_valid=0 is ignored.
- ERR:
  - All handshake outputs are low; only reset_n exits.
- Arithmetic: no arithmetic in this block; the product width and saturation are owned by the multiplier. Values pass through bit-exact.
- Sequence of one gate with gate_last=1: result = G x I = G.
- Throughput: one gate per 4 cycles minimum (IDLE, ISSUE, WAIT x2).

Test Plan:
- Reset, then a single X gate ([0][1][0]=[1][0][0]=131072, rest 0) with gate_last=1:
  - mul_ready pulses once.
  - result_valid rises 4 cycles after acceptance.
  - result_mtx equals X; gate_count=1.
- Sequence X, X (last on 2nd):
  - result_mtx = identity (131072 on diagonal real).
  - gate_count=2; exactly two mul_ready pulses.
- Hold gate_valid high continuously with 3 gates:
  - gate_ready is high only in IDLE cycles.
  - Each gate is accepted exactly once, no duplicates.
  - mul_b on each ISSUE equals the previous product.
- Multiplier model never asserts mul_completed:
  - error=1 after 8 WAIT cycles; gate_ready stays 0.
  - Recovery only after reset_n pulse low, which gives identity accumulator and error=0.
- In DONE, delay result_ack by 5 cycles:
  - result_mtx and result_valid stay stable.
  - After ack: next sequence of a single gate G yields G, confirming the accumulator was reset to identity.
- Assert reset_n low asynchronously (between clock edges) during WAIT:
  - Outputs clear immediately.
  - A late mul_completed after reset release is ignored.
  - The accumulator remains identity.
